// File: rtl/key_debounce_conditioner_if.sv
// Key conditioner bundle: raw active-low keys and clears in,
// debounced levels, strobes and sticky flags out.
interface key_debounce_conditioner_if #(
   parameter int N_KEYS = 4
);
   logic [N_KEYS-1:0] key_n_in;
   logic [N_KEYS-1:0] event_clr;
   logic [N_KEYS-1:0] key_n_out;
   logic [N_KEYS-1:0] press_pulse;
   logic [N_KEYS-1:0] release_pulse;
   logic [N_KEYS-1:0] event_sticky;

   modport master (
      output key_n_in,
      output event_clr,
      input  key_n_out,
      input  press_pulse,
      input  release_pulse,
      input  event_sticky
   );

   modport slave (
      input  key_n_in,
      input  event_clr,
      output key_n_out,
      output press_pulse,
      output release_pulse,
      output event_sticky
   );
endinterface

// File: rtl/key_debounce_conditioner.sv
// Per-key synchronizer plus counter debounce FSM producing a clean
// active-low level, press/release strobes and sticky press flags.
module key_debounce_conditioner #(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input logic                       Clk,
   input logic                       Reset_n,
   key_debounce_conditioner_if.slave io
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_e;

   logic [N_KEYS-1:0] s1_q, s1_d;
   logic [N_KEYS-1:0] s2_q, s2_d;
   state_e            state_q [N_KEYS];
   state_e            state_d [N_KEYS];
   logic [CNT_W-1:0]  cnt_q [N_KEYS];
   logic [CNT_W-1:0]  cnt_d [N_KEYS];
   logic [N_KEYS-1:0] key_n_q, key_n_d;
   logic [N_KEYS-1:0] press_q, press_d;
   logic [N_KEYS-1:0] rel_q, rel_d;
   logic [N_KEYS-1:0] sticky_q, sticky_d;
   logic [N_KEYS-1:0] done;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_q     <= '1;
         s2_q     <= '1;
         key_n_q  <= '1;
         press_q  <= '0;
         rel_q    <= '0;
         sticky_q <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            state_q[i] <= RELEASED;
            cnt_q[i]   <= '0;
         end
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         key_n_q  <= key_n_d;
         press_q  <= press_d;
         rel_q    <= rel_d;
         sticky_q <= sticky_d;
         for (int i = 0; i < N_KEYS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   always_comb begin
      s1_d = io.key_n_in;
      s2_d = s1_q;
      done = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         done[i] = (cnt_q[i] == CNT_MAX);
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         unique case (state_q[i])
            RELEASED: begin
               if (!s2_q[i]) begin
                  state_d[i] = PRESS_WAIT;
                  cnt_d[i]   = '0;
               end
            end
            PRESS_WAIT: begin
               if (s2_q[i]) begin
                  state_d[i] = RELEASED;
                  cnt_d[i]   = '0;
               end else if (done[i]) begin
                  state_d[i] = PRESSED;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (s2_q[i]) begin
                  state_d[i] = RELEASE_WAIT;
                  cnt_d[i]   = '0;
               end
            end
            RELEASE_WAIT: begin
               if (!s2_q[i]) begin
                  state_d[i] = PRESSED;
                  cnt_d[i]   = '0;
               end else if (done[i]) begin
                  state_d[i] = RELEASED;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = RELEASED;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // Set beats clear so a press landing on a clear is never lost.
   always_comb begin
      key_n_d = key_n_q;
      press_d = '0;
      rel_d   = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (state_q[i] == PRESS_WAIT && !s2_q[i] && done[i]) begin
            key_n_d[i] = 1'b0;
            press_d[i] = 1'b1;
         end
         if (state_q[i] == RELEASE_WAIT && s2_q[i] && done[i]) begin
            key_n_d[i] = 1'b1;
            rel_d[i]   = 1'b1;
         end
      end
      sticky_d = (sticky_q & ~io.event_clr) | press_d;
   end

   assign io.key_n_out     = key_n_q;
   assign io.press_pulse   = press_q;
   assign io.release_pulse = rel_q;
   assign io.event_sticky  = sticky_q;
endmodule

// File: tb/tb_key_debounce_conditioner.sv
// Bench for key_debounce_conditioner: directed scenarios plus random
// bouncing keys against a run-length reference model.
module tb_key_debounce_conditioner;
   localparam int N = 4;
   localparam int D = 8;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 Clk = ~Clk;

   key_debounce_conditioner_if #(.N_KEYS(N)) kif ();

   key_debounce_conditioner #(
      .N_KEYS(N),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .io(kif)
   );

   // Reference: input seen two edges late; a level is accepted once
   // it has disagreed with the output for D+1 consecutive edges.
   logic [N-1:0] m_dly0, m_dly1, m_out, m_press, m_rel, m_sticky;
   int           m_run [N];

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m_dly0 = '1;
         m_dly1 = '1;
         m_out = '1;
         m_press = '0;
         m_rel = '0;
         m_sticky = '0;
         for (int k = 0; k < N; k++) m_run[k] = 0;
      end else begin
         m_press = '0;
         m_rel = '0;
         for (int k = 0; k < N; k++) begin
            if (m_dly1[k] != m_out[k]) begin
               m_run[k]++;
               if (m_run[k] == D + 1) begin
                  m_out[k] = m_dly1[k];
                  if (m_dly1[k]) m_rel[k] = 1'b1;
                  else m_press[k] = 1'b1;
                  m_run[k] = 0;
               end
            end else begin
               m_run[k] = 0;
            end
         end
         m_sticky = (m_sticky & ~kif.event_clr) | m_press;
         m_dly1 = m_dly0;
         m_dly0 = kif.key_n_in;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
      chk("m_key_n_out", 32'(kif.key_n_out), 32'(m_out));
      chk("m_press", 32'(kif.press_pulse), 32'(m_press));
      chk("m_release", 32'(kif.release_pulse), 32'(m_rel));
      chk("m_sticky", 32'(kif.event_sticky), 32'(m_sticky));
   endtask

   task automatic wait_pulse(input int k, input bit rel, output int edges);
      edges = -1;
      for (int e = 0; e < 40; e++) begin
         tick();
         if (rel ? kif.release_pulse[k] : kif.press_pulse[k]) begin
            edges = e;
            break;
         end
      end
   endtask

   int lat;
   int npulse;
   int hold [N];

   initial begin
      kif.key_n_in = '0;
      kif.event_clr = '0;
      repeat (3) tick();
      chk("rst_key_n_out", 32'(kif.key_n_out), 32'hf);
      chk("rst_press", 32'(kif.press_pulse), 32'h0);
      chk("rst_release", 32'(kif.release_pulse), 32'h0);
      chk("rst_sticky", 32'(kif.event_sticky), 32'h0);

      Reset_n = 1'b1;
      wait_pulse(0, 1'b0, lat);
      chk("rst_exit_lat", 32'(lat), 32'd10);
      chk("rst_exit_level", 32'(kif.key_n_out), 32'h0);
      chk("rst_exit_press", 32'(kif.press_pulse), 32'hf);

      kif.key_n_in = '1;
      repeat (15) tick();
      kif.event_clr = '1;
      tick();
      kif.event_clr = '0;
      chk("clr_all", 32'(kif.event_sticky), 32'h0);

      kif.key_n_in[1] = 1'b0;
      wait_pulse(1, 1'b0, lat);
      chk("press_lat", 32'(lat), 32'd10);
      chk("press_level", 32'(kif.key_n_out), 32'hd);
      chk("press_vec", 32'(kif.press_pulse), 32'h2);
      chk("press_sticky", 32'(kif.event_sticky[1]), 32'h1);
      tick();
      chk("press_one_cyc", 32'(kif.press_pulse), 32'h0);

      kif.key_n_in[1] = 1'b1;
      wait_pulse(1, 1'b1, lat);
      chk("rel_lat", 32'(lat), 32'd10);
      chk("rel_level", 32'(kif.key_n_out), 32'hf);
      chk("rel_sticky_hold", 32'(kif.event_sticky[1]), 32'h1);
      tick();
      chk("rel_one_cyc", 32'(kif.release_pulse), 32'h0);
      kif.event_clr[1] = 1'b1;
      tick();
      kif.event_clr[1] = 1'b0;
      chk("sticky_clr", 32'(kif.event_sticky[1]), 32'h0);

      npulse = 0;
      for (int r = 0; r < 6; r++) begin
         kif.key_n_in[2] = 1'b0;
         repeat (5) begin
            tick();
            npulse += int'(kif.press_pulse[2]) + int'(kif.release_pulse[2]);
         end
         kif.key_n_in[2] = 1'b1;
         repeat (3) begin
            tick();
            npulse += int'(kif.press_pulse[2]) + int'(kif.release_pulse[2]);
         end
      end
      chk("bounce_pulses", 32'(npulse), 32'd0);
      chk("bounce_level", 32'(kif.key_n_out[2]), 32'h1);
      kif.key_n_in[2] = 1'b0;
      wait_pulse(2, 1'b0, lat);
      chk("bounce_lat", 32'(lat), 32'd10);

      kif.key_n_in[3] = 1'b0;
      repeat (10) tick();
      kif.event_clr[3] = 1'b1;
      tick();
      chk("coll_press", 32'(kif.press_pulse[3]), 32'h1);
      chk("coll_sticky", 32'(kif.event_sticky[3]), 32'h1);
      tick();
      kif.event_clr[3] = 1'b0;
      chk("coll_clr", 32'(kif.event_sticky[3]), 32'h0);

      kif.key_n_in[0] = 1'b0;
      repeat (8) tick();
      #2 Reset_n = 1'b0;
      #1;
      chk("async_level", 32'(kif.key_n_out), 32'hf);
      chk("async_press", 32'(kif.press_pulse), 32'h0);
      chk("async_sticky", 32'(kif.event_sticky), 32'h0);
      tick();
      Reset_n = 1'b1;
      wait_pulse(0, 1'b0, lat);
      chk("mid_rst_lat", 32'(lat), 32'd10);

      for (int k = 0; k < N; k++) hold[k] = 0;
      repeat (2500) begin
         for (int k = 0; k < N; k++) begin
            if (hold[k] == 0) begin
               kif.key_n_in[k] = 1'($urandom_range(0, 1));
               hold[k] = $urandom_range(1, 14);
            end else begin
               hold[k]--;
            end
            kif.event_clr[k] = ($urandom_range(0, 7) == 0);
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
